// File: rtl/power_sequencer.sv
// Power-up sequencer: raises per-stage enables in order, waits for each
// stage's ready acknowledge with a settle delay and timeout, retries the
// whole sequence a bounded number of times and latches a fault otherwise.
module power_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned OFF_CYCLES  = 62,
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic [NUM_STAGES-1:0] rdy,
    output logic [NUM_STAGES-1:0] en,
    output logic                  all_ready,
    output logic                  busy,
    output logic                  fault,
    output logic [7:0]            fault_stage,
    output logic [7:0]            retry_cnt
);

    localparam int unsigned STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned OUT_W   = 8;

    typedef enum logic [2:0] {
        S_OFF,
        S_DELAY,
        S_WAIT,
        S_RUN,
        S_FAULT
    } state_e;

    state_e                  state_q, state_d;
    logic [STAGE_W-1:0]      stage_q, stage_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OUT_W-1:0]        retry_q, retry_d;
    logic [OUT_W-1:0]        fault_stage_q, fault_stage_d;
    logic [NUM_STAGES-1:0]   en_q, en_d;
    logic                    all_ready_q, all_ready_d;
    logic                    busy_q, busy_d;
    logic                    fault_q, fault_d;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_OFF;
            stage_q       <= '0;
            cnt_q         <= '0;
            retry_q       <= '0;
            fault_stage_q <= '0;
            en_q          <= '0;
            all_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            fault_stage_q <= fault_stage_d;
            en_q          <= en_d;
            all_ready_q   <= all_ready_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
        end
    end

    // Next-state logic; enables only ever grow by one bit or clear entirely
    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        cnt_d         = cnt_q;
        retry_d       = retry_q;
        fault_stage_d = fault_stage_q;
        en_d          = en_q;

        if (restart) begin
            state_d = S_OFF;
            stage_d = '0;
            cnt_d   = '0;
            retry_d = '0;
            en_d    = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    en_d = '0;
                    if (cnt_q == CNT_W'(OFF_CYCLES - 1)) begin
                        en_d    = NUM_STAGES'(1);
                        stage_d = '0;
                        cnt_d   = '0;
                        state_d = S_DELAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DELAY: begin
                    if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // ready is checked before timeout so a same-edge ready wins
                    if (rdy[stage_q]) begin
                        cnt_d = '0;
                        if (stage_q == STAGE_W'(NUM_STAGES - 1)) begin
                            state_d = S_RUN;
                        end else begin
                            en_d    = (en_q << 1) | NUM_STAGES'(1);
                            stage_d = stage_q + STAGE_W'(1);
                            state_d = S_DELAY;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        fault_stage_d = OUT_W'(stage_q);
                        en_d          = '0;
                        cnt_d         = '0;
                        stage_d       = '0;
                        if (retry_q < OUT_W'(MAX_RETRY)) begin
                            retry_d = retry_q + OUT_W'(1);
                            state_d = S_OFF;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // losing any ready in RUN starts a fresh sequence, not a retry
                    if (!(&rdy)) begin
                        en_d    = '0;
                        retry_d = '0;
                        stage_d = '0;
                        cnt_d   = '0;
                        state_d = S_OFF;
                    end
                end
                S_FAULT: begin
                    en_d = '0;
                end
                default: begin
                    en_d    = '0;
                    stage_d = '0;
                    cnt_d   = '0;
                    state_d = S_OFF;
                end
            endcase
        end

        all_ready_d = (state_d == S_RUN);
        busy_d      = (state_d == S_OFF) || (state_d == S_DELAY) || (state_d == S_WAIT);
        fault_d     = (state_d == S_FAULT);
    end

    assign en          = en_q;
    assign all_ready   = all_ready_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;
    assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Scoreboard bench for power_sequencer: expected output vectors are queued
// against the edge number (counted from rst release) and checked after it.
module tb_power_sequencer;

    localparam int unsigned NS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          restart;
    logic [NS-1:0] rdy;
    logic [NS-1:0] en;
    logic          all_ready;
    logic          busy;
    logic          fault;
    logic [7:0]    fault_stage;
    logic [7:0]    retry_cnt;

    always #5 clk = ~clk;

    power_sequencer #(
        .NUM_STAGES (3),
        .OFF_CYCLES (4),
        .STAGE_DELAY(3),
        .TIMEOUT    (10),
        .MAX_RETRY  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .rdy        (rdy),
        .en         (en),
        .all_ready  (all_ready),
        .busy       (busy),
        .fault      (fault),
        .fault_stage(fault_stage),
        .retry_cnt  (retry_cnt)
    );

    // vector layout: {en[2:0], all_ready, busy, fault, fault_stage[7:0], retry_cnt[7:0]}
    typedef struct {
        int          edge_no;
        logic [21:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [21:0] mk(input logic [2:0] e, input logic ar, input logic b,
                                       input logic f, input logic [7:0] fs, input logic [7:0] rc);
        return {e, ar, b, f, fs, rc};
    endfunction

    function automatic logic [21:0] obs();
        return {en, all_ready, busy, fault, fault_stage, retry_cnt};
    endfunction

    task automatic push(input int edge_no, input logic [21:0] v, input string name);
        exp_t e;
        e.edge_no = edge_no;
        e.v       = v;
        e.name    = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rdy     = 3'b000;
        restart = 1'b0;
        do_reset();
        n_tests++;
        if (obs() !== mk(3'b000, 0, 1, 0, 8'd0, 8'd0)) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", obs(), mk(3'b000, 0, 1, 0, 8'd0, 8'd0));
        end
    endtask

    task automatic test_nominal();
        exp_t e;
        rdy = 3'b111;
        do_reset();
        push(3,  mk(3'b000, 0, 1, 0, 8'd0, 8'd0), "nom_off");
        push(4,  mk(3'b001, 0, 1, 0, 8'd0, 8'd0), "nom_en0");
        push(7,  mk(3'b001, 0, 1, 0, 8'd0, 8'd0), "nom_wait0");
        push(8,  mk(3'b011, 0, 1, 0, 8'd0, 8'd0), "nom_en1");
        push(12, mk(3'b111, 0, 1, 0, 8'd0, 8'd0), "nom_en2");
        push(15, mk(3'b111, 0, 1, 0, 8'd0, 8'd0), "nom_pre_run");
        push(16, mk(3'b111, 1, 0, 0, 8'd0, 8'd0), "nom_run");
        push(20, mk(3'b111, 1, 0, 0, 8'd0, 8'd0), "nom_run_hold");
        for (int n = 1; n <= 20; n++) begin
            tick();
            while (sb.size() > 0 && sb[0].edge_no == n) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %h expected %h", e.name, n, obs(), e.v);
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL nom_leftover: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_timeout_fault();
        exp_t e;
        rdy = 3'b110;
        do_reset();
        push(3,   mk(3'b000, 0, 1, 0, 8'd0, 8'd0), "to_off");
        push(4,   mk(3'b001, 0, 1, 0, 8'd0, 8'd0), "to_en0");
        push(16,  mk(3'b001, 0, 1, 0, 8'd0, 8'd0), "to_pre1");
        push(17,  mk(3'b000, 0, 1, 0, 8'd0, 8'd1), "to_first");
        push(20,  mk(3'b000, 0, 1, 0, 8'd0, 8'd1), "to_off2");
        push(21,  mk(3'b001, 0, 1, 0, 8'd0, 8'd1), "to_en0_again");
        push(33,  mk(3'b001, 0, 1, 0, 8'd0, 8'd1), "to_pre2");
        push(34,  mk(3'b000, 0, 1, 0, 8'd0, 8'd2), "to_second");
        push(38,  mk(3'b001, 0, 1, 0, 8'd0, 8'd2), "to_en0_third");
        push(50,  mk(3'b001, 0, 1, 0, 8'd0, 8'd2), "to_pre3");
        push(51,  mk(3'b000, 0, 0, 1, 8'd0, 8'd2), "to_fault");
        push(100, mk(3'b000, 0, 0, 1, 8'd0, 8'd2), "to_fault_hold");
        push(151, mk(3'b000, 0, 0, 1, 8'd0, 8'd2), "to_fault_persist");
        for (int n = 1; n <= 151; n++) begin
            tick();
            while (sb.size() > 0 && sb[0].edge_no == n) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %h expected %h", e.name, n, obs(), e.v);
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL to_leftover: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Continues from the FAULT state left by test_timeout_fault
    task automatic test_restart();
        exp_t e;
        rdy     = 3'b111;
        restart = 1'b1;
        push(1,  mk(3'b000, 0, 1, 0, 8'd0, 8'd0), "rs_clear");
        push(5,  mk(3'b001, 0, 1, 0, 8'd0, 8'd0), "rs_en0");
        push(16, mk(3'b111, 0, 1, 0, 8'd0, 8'd0), "rs_pre_run");
        push(17, mk(3'b111, 1, 0, 0, 8'd0, 8'd0), "rs_run");
        for (int n = 1; n <= 17; n++) begin
            tick();
            if (n == 1) restart = 1'b0;
            while (sb.size() > 0 && sb[0].edge_no == n) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %h expected %h", e.name, n, obs(), e.v);
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rs_leftover: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_run_drop();
        exp_t e;
        rdy = 3'b110;
        do_reset();
        push(17, mk(3'b000, 0, 1, 0, 8'd0, 8'd1), "rd_timeout");
        push(21, mk(3'b001, 0, 1, 0, 8'd0, 8'd1), "rd_en0");
        push(33, mk(3'b111, 1, 0, 0, 8'd0, 8'd1), "rd_run");
        push(34, mk(3'b111, 1, 0, 0, 8'd0, 8'd1), "rd_run_hold");
        push(35, mk(3'b000, 0, 1, 0, 8'd0, 8'd0), "rd_drop");
        push(39, mk(3'b001, 0, 1, 0, 8'd0, 8'd0), "rd_reseq_en0");
        push(50, mk(3'b111, 0, 1, 0, 8'd0, 8'd0), "rd_reseq_pre");
        push(51, mk(3'b111, 1, 0, 0, 8'd0, 8'd0), "rd_reseq_run");
        for (int n = 1; n <= 52; n++) begin
            tick();
            if (n == 17) rdy = 3'b111;
            if (n == 34) rdy = 3'b101;
            if (n == 35) rdy = 3'b111;
            n_tests++;
            if (!(en inside {3'b000, 3'b001, 3'b011, 3'b111})) begin
                n_fail++;
                $display("FAIL thermo edge %0d: got en=%b expected thermometer code", n, en);
            end
            while (sb.size() > 0 && sb[0].edge_no == n) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %h expected %h", e.name, n, obs(), e.v);
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rd_leftover: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_ready_at_timeout();
        exp_t e;
        rdy = 3'b101;
        do_reset();
        push(11, mk(3'b011, 0, 1, 0, 8'd0, 8'd0), "rt_wait1");
        push(20, mk(3'b011, 0, 1, 0, 8'd0, 8'd0), "rt_pre");
        push(21, mk(3'b111, 0, 1, 0, 8'd0, 8'd0), "rt_ready_wins");
        push(25, mk(3'b111, 1, 0, 0, 8'd0, 8'd0), "rt_run");
        for (int n = 1; n <= 25; n++) begin
            tick();
            if (n == 20) rdy = 3'b111;
            while (sb.size() > 0 && sb[0].edge_no == n) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %h expected %h", e.name, n, obs(), e.v);
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rt_leftover: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Stage-1 timeout first (nonzero fault_stage/retry), then rst during stage-2 DELAY
    task automatic test_reset_mid();
        exp_t e;
        rdy = 3'b101;
        do_reset();
        push(21, mk(3'b000, 0, 1, 0, 8'd1, 8'd1), "rm_timeout1");
        push(25, mk(3'b001, 0, 1, 0, 8'd1, 8'd1), "rm_en0");
        push(33, mk(3'b111, 0, 1, 0, 8'd1, 8'd1), "rm_en2");
        push(34, mk(3'b000, 0, 1, 0, 8'd0, 8'd0), "rm_reset_vals");
        push(37, mk(3'b000, 0, 1, 0, 8'd0, 8'd0), "rm_off");
        push(38, mk(3'b001, 0, 1, 0, 8'd0, 8'd0), "rm_en0_again");
        push(50, mk(3'b111, 1, 0, 0, 8'd0, 8'd0), "rm_run");
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (n == 21) rdy = 3'b111;
            if (n == 33) rst = 1'b1;
            if (n == 34) rst = 1'b0;
            while (sb.size() > 0 && sb[0].edge_no == n) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %h expected %h", e.name, n, obs(), e.v);
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rm_leftover: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst     = 1'b1;
        restart = 1'b0;
        rdy     = '0;
        test_reset();
        test_nominal();
        test_timeout_fault();
        test_restart();
        test_run_drop();
        test_ready_at_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
